// File: rtl/dct_sequencer.sv
// DMA-style job sequencer for the DCT peripheral. It loads samples from memory into the DCT,
// then copies the DCT results back to memory, all under a config-register interface.
module dct_sequencer #(
  parameter int NBITS    = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_SIZE = 256
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [2:0]        cfg_address,
  input  logic              cfg_write,
  input  logic              cfg_read,
  input  logic [15:0]       cfg_writedata,
  output logic [15:0]       cfg_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [NBITS-1:0]  mem_writedata,
  input  logic [NBITS-1:0]  mem_readdata,
  input  logic              mem_waitrequest,
  output logic [7:0]        dct_address,
  output logic              dct_read,
  output logic              dct_write,
  output logic [NBITS-1:0]  dct_writedata,
  input  logic [NBITS-1:0]  dct_readdata,
  input  logic              dct_done,
  output logic              irq
);

  typedef enum logic [2:0] {
    IDLE, SETQ, START, LOAD_RD, LOAD_WR, RES_RD, RES_WR, FIN
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_SIZE);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  src, dst;
  logic [15:0]        len, qm;
  logic [8:0]         i_cnt, k_cnt;
  logic [NBITS-1:0]   sample, result;
  logic               irq_en, done_flag, err;
  logic               busy, ctrl_wr, go, len_ok;
  logic [8:0]         last_idx;

  assign busy     = (state != IDLE);
  assign ctrl_wr  = cfg_write && (cfg_address == 3'd0);
  assign go       = ctrl_wr && cfg_writedata[0] && !busy;
  assign len_ok   = (len >= 16'd2) && ({1'b0, len} <= MAX_LEN);
  assign last_idx = len[8:0] - 9'd1;
  assign irq      = done_flag && irq_en;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      qm        <= '0;
      i_cnt     <= '0;
      k_cnt     <= '0;
      sample    <= '0;
      result    <= '0;
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (cfg_write && !busy) begin
        case (cfg_address)
          3'd1:    src <= ADDR_W'(cfg_writedata);
          3'd2:    dst <= ADDR_W'(cfg_writedata);
          3'd3:    len <= cfg_writedata;
          3'd4:    qm  <= cfg_writedata;
          default: ;
        endcase
      end
      // irq_en stays writable mid-job so software can arm the interrupt late
      if (ctrl_wr) irq_en <= cfg_writedata[1];
      if (go) begin
        err       <= !len_ok;
        done_flag <= 1'b0;
      end
      case (state)
        START:   i_cnt <= '0;
        LOAD_RD: if (!mem_waitrequest) sample <= mem_readdata;
        LOAD_WR: begin
          i_cnt <= i_cnt + 9'd1;
          if (i_cnt == last_idx) k_cnt <= '0;
        end
        RES_RD:  if (dct_done) result <= dct_readdata;
        RES_WR:  if (!mem_waitrequest) k_cnt <= k_cnt + 9'd1;
        FIN:     done_flag <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    mem_address   = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = '0;
    dct_address   = '0;
    dct_read      = 1'b0;
    dct_write     = 1'b0;
    dct_writedata = '0;
    case (state)
      IDLE: if (go && len_ok) state_next = SETQ;
      SETQ: begin
        dct_write     = 1'b1;
        dct_address   = 8'd3;
        dct_writedata = NBITS'(qm);
        state_next    = START;
      end
      START: begin
        // a LEN write also re-initialises the DCT, which makes abandoned jobs harmless
        dct_write     = 1'b1;
        dct_address   = 8'd0;
        dct_writedata = NBITS'(len);
        state_next    = LOAD_RD;
      end
      LOAD_RD: begin
        mem_read    = 1'b1;
        mem_address = src + ADDR_W'(i_cnt);
        if (!mem_waitrequest) state_next = LOAD_WR;
      end
      LOAD_WR: begin
        dct_write     = 1'b1;
        dct_address   = 8'd1;
        dct_writedata = sample;
        state_next    = (i_cnt == last_idx) ? RES_RD : LOAD_RD;
      end
      RES_RD: begin
        dct_read    = 1'b1;
        dct_address = k_cnt[7:0];
        if (dct_done) state_next = RES_WR;
      end
      RES_WR: begin
        mem_write     = 1'b1;
        mem_address   = dst + ADDR_W'(k_cnt);
        mem_writedata = result;
        if (!mem_waitrequest) state_next = (k_cnt == last_idx) ? FIN : RES_RD;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_readdata = '0;
    if (cfg_read) begin
      case (cfg_address)
        3'd1:    cfg_readdata = 16'(src);
        3'd2:    cfg_readdata = 16'(dst);
        3'd3:    cfg_readdata = len;
        3'd4:    cfg_readdata = qm;
        3'd5:    cfg_readdata = {13'd0, err, done_flag, busy};
        default: cfg_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_sequencer.sv
// Directed/random bench for dct_sequencer with a memory model and a DCT stand-in whose result k
// is sample[k] + QM*k + LEN, so every routing or indexing slip changes the stored data.
module tb_dct_sequencer;
  logic        clk = 1'b0;
  logic        Reset;
  logic [2:0]  cfg_address = '0;
  logic        cfg_write = 1'b0, cfg_read = 1'b0;
  logic [15:0] cfg_writedata = '0, cfg_readdata;
  logic [15:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write;
  logic        mem_waitrequest = 1'b0;
  logic [7:0]  dct_address;
  logic        dct_read, dct_write;
  logic [15:0] dct_writedata, dct_readdata;
  logic        dct_done = 1'b1;
  logic        irq;

  always #5 clk = ~clk;

  dct_sequencer #(.NBITS(16), .ADDR_W(16), .MAX_SIZE(256)) dut (
    .clk(clk), .Reset(Reset),
    .cfg_address(cfg_address), .cfg_write(cfg_write), .cfg_read(cfg_read),
    .cfg_writedata(cfg_writedata), .cfg_readdata(cfg_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .dct_address(dct_address), .dct_read(dct_read), .dct_write(dct_write),
    .dct_writedata(dct_writedata), .dct_readdata(dct_readdata), .dct_done(dct_done),
    .irq(irq)
  );

  // source memory (written only by the stimulus) and logs of what the DUT did
  logic [15:0] src_mem [0:65535];
  logic [15:0] s_len, s_qm;
  logic [15:0] s_smp [0:255];
  int          s_cnt;
  logic [31:0] wr_log[$];
  logic [15:0] rd_log[$];
  logic [23:0] dct_log[$];
  int          strobe_cnt = 0, onehot_viol = 0, hold_viol = 0;
  bit          wait_en = 1'b0, stall_en = 1'b0;
  bit          hold_prev = 1'b0, h_rd, h_wr;
  logic [15:0] h_addr, h_data;

  assign mem_readdata = src_mem[mem_address];
  assign dct_readdata = s_smp[dct_address] + s_qm * {8'd0, dct_address} + s_len;

  always @(posedge clk) begin
    if (mem_read && !mem_waitrequest) rd_log.push_back(mem_address);
    if (mem_write && !mem_waitrequest) wr_log.push_back({mem_address, mem_writedata});
    if (mem_read || mem_write || dct_read || dct_write) strobe_cnt++;
    if (dct_write) begin
      dct_log.push_back({dct_address, dct_writedata});
      case (dct_address)
        8'd0: begin s_len <= dct_writedata; s_cnt <= 0; end
        8'd3: s_qm <= dct_writedata;
        8'd1: begin s_smp[s_cnt[7:0]] <= dct_writedata; s_cnt <= s_cnt + 1; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!Reset) begin
      if ($countones({mem_read, mem_write, dct_read, dct_write}) > 1) onehot_viol++;
      if (hold_prev && (mem_address !== h_addr || mem_read !== h_rd || mem_write !== h_wr ||
                        (h_wr && mem_writedata !== h_data))) hold_viol++;
    end
    mem_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
    dct_done        = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    hold_prev = !Reset && (mem_read || mem_write) && mem_waitrequest;
    h_addr = mem_address; h_data = mem_writedata; h_rd = mem_read; h_wr = mem_write;
  end

  int compared = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_address = a; cfg_writedata = d; cfg_write = 1'b1;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    cfg_address = a; cfg_read = 1'b1;
    #1 d = cfg_readdata;
    cfg_read = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] src, dst, len, qm, input bit ie);
    cfg_wr(3'd1, src); cfg_wr(3'd2, dst); cfg_wr(3'd3, len); cfg_wr(3'd4, qm);
    cfg_wr(3'd0, {14'd0, ie, 1'b1});
  endtask

  // counts busy cycles starting with the cycle right after the GO write
  task automatic wait_idle(output int n);
    logic [15:0] s;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      rd(3'd5, s);
      if (!s[0]) break;
      n++;
      @(negedge clk);
    end
    rd(3'd5, s);
    check("job_finishes_in_budget", 64'(s[0]), 64'd0);
  endtask

  task automatic check_job(input string tag, input logic [15:0] src, dst, len, qm,
                           input int wb, input int db);
    logic [15:0] ed;
    check({tag, " mem_writes"}, 64'(wr_log.size() - wb), 64'(len));
    for (int k = 0; k < int'(len); k++) begin
      ed = 16'(src_mem[16'(src + k)] + qm * k + len);
      check($sformatf("%s result%0d", tag, k), 64'(wr_log[wb + k]), {32'd0, 16'(dst + k), ed});
    end
    check({tag, " dct_writes"}, 64'(dct_log.size() - db), 64'(len + 2));
    check({tag, " setq"}, 64'(dct_log[db]), {40'd0, 8'd3, qm});
    check({tag, " start"}, 64'(dct_log[db + 1]), {40'd0, 8'd0, len});
    for (int i = 0; i < int'(len); i++)
      check($sformatf("%s load%0d", tag, i), 64'(dct_log[db + 2 + i]),
            {40'd0, 8'd1, src_mem[16'(src + i)]});
    check({tag, " one_strobe"}, 64'(onehot_viol), 64'd0);
    check({tag, " stall_hold"}, 64'(hold_viol), 64'd0);
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] res1 [0:15];
    int n, wb, db, rb, sc;

    // reset state
    Reset = 1'b1;
    #1;
    check("reset_outputs", {mem_address, mem_read, mem_write, mem_writedata, dct_address,
                            dct_read, dct_write, dct_writedata, irq}, 64'd0);
    cfg_address = 3'd5;
    #1 check("readdata_idle_zero", 64'(cfg_readdata), 64'd0);
    rd(3'd5, s);
    check("reset_status", 64'(s), 64'd0);
    @(negedge clk); @(negedge clk);
    Reset = 1'b0;

    // job A: four equal samples, irq enabled, zero waits
    for (int i = 0; i < 4; i++) src_mem[16'h0100 + i] = 16'h1000;
    wb = wr_log.size(); db = dct_log.size();
    start_job(16'h0100, 16'h0200, 16'd4, 16'd3, 1'b1);
    wait_idle(n);
    check("jobA busy_cycles", 64'(n), 64'd19);
    rd(3'd5, s);
    check("jobA status", 64'(s), 64'h2);
    check("jobA irq", 64'(irq), 64'd1);
    check_job("jobA", 16'h0100, 16'h0200, 16'd4, 16'd3, wb, db);

    // invalid lengths: err set, done cleared, no bus activity
    sc = strobe_cnt;
    cfg_wr(3'd3, 16'd1); cfg_wr(3'd0, 16'h3);
    repeat (3) @(negedge clk);
    rd(3'd5, s);
    check("len1 status", 64'(s), 64'h4);
    check("len1 irq", 64'(irq), 64'd0);
    cfg_wr(3'd3, 16'd257); cfg_wr(3'd0, 16'h1);
    repeat (3) @(negedge clk);
    rd(3'd5, s);
    check("len257 status", 64'(s), 64'h4);
    check("bad_go no_strobes", 64'(strobe_cnt - sc), 64'd0);

    // LEN=16 zero-wait run, then the same job with random memory waits and DCT stalls
    for (int i = 0; i < 16; i++) src_mem[16'h0300 + i] = 16'($urandom);
    wb = wr_log.size(); db = dct_log.size();
    start_job(16'h0300, 16'h0400, 16'd16, 16'd9, 1'b0);
    wait_idle(n);
    check("len16 busy_cycles", 64'(n), 64'd67);
    rd(3'd5, s);
    check("len16 status", 64'(s), 64'h2);
    check_job("len16_nowait", 16'h0300, 16'h0400, 16'd16, 16'd9, wb, db);
    for (int k = 0; k < 16; k++) res1[k] = wr_log[wb + k][15:0];
    wait_en = 1'b1; stall_en = 1'b1;
    wb = wr_log.size(); db = dct_log.size();
    start_job(16'h0300, 16'h0500, 16'd16, 16'd9, 1'b0);
    wait_idle(n);
    check("len16 stalls_seen", 64'(n > 67), 64'd1);
    check_job("len16_wait", 16'h0300, 16'h0500, 16'd16, 16'd9, wb, db);
    for (int k = 0; k < 16; k++)
      check($sformatf("len16 same_as_nowait%0d", k), 64'(wr_log[wb + k][15:0]), 64'(res1[k]));
    wait_en = 1'b0; stall_en = 1'b0;
    @(negedge clk);

    // config writes while busy are ignored except irq_en
    for (int i = 0; i < 6; i++) src_mem[16'h0600 + i] = 16'($urandom);
    wb = wr_log.size(); db = dct_log.size();
    start_job(16'h0600, 16'h0700, 16'd6, 16'd5, 1'b0);
    cfg_wr(3'd1, 16'h0900); cfg_wr(3'd3, 16'd3); cfg_wr(3'd0, 16'h3);
    wait_idle(n);
    check_job("busywr", 16'h0600, 16'h0700, 16'd6, 16'd5, wb, db);
    rd(3'd5, s);
    check("busywr status", 64'(s), 64'h2);
    check("busywr irq", 64'(irq), 64'd1);
    rd(3'd1, s);
    check("busywr src_kept", 64'(s), 64'h0600);
    rd(3'd3, s);
    check("busywr len_kept", 64'(s), 64'd6);

    // reset in LOAD_RD of one job, then a clean LEN=8 job
    for (int i = 0; i < 8; i++) src_mem[16'h0C00 + i] = 16'($urandom);
    start_job(16'h0A00, 16'h0B00, 16'd8, 16'd2, 1'b1);
    @(negedge clk); @(negedge clk);
    check("rst in_load_rd", 64'(mem_read), 64'd1);
    #1 Reset = 1'b1;
    #1;
    check("rst outputs", {mem_address, mem_read, mem_write, mem_writedata, dct_address,
                          dct_read, dct_write, dct_writedata, irq}, 64'd0);
    rd(3'd5, s);
    check("rst status", 64'(s), 64'd0);
    @(negedge clk); @(negedge clk);
    Reset = 1'b0;
    wb = wr_log.size(); db = dct_log.size();
    start_job(16'h0C00, 16'h0D00, 16'd8, 16'd7, 1'b0);
    wait_idle(n);
    check("job2 busy_cycles", 64'(n), 64'd35);
    check_job("job2", 16'h0C00, 16'h0D00, 16'd8, 16'd7, wb, db);

    // source address wraps at the top of the address space
    src_mem[16'hFFFE] = 16'h1111; src_mem[16'hFFFF] = 16'h2222;
    src_mem[16'h0000] = 16'h3333; src_mem[16'h0001] = 16'h4444;
    wb = wr_log.size(); db = dct_log.size(); rb = rd_log.size();
    start_job(16'hFFFE, 16'h0E00, 16'd4, 16'd1, 1'b0);
    wait_idle(n);
    check("wrap reads", 64'(rd_log.size() - rb), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap addr%0d", i), 64'(rd_log[rb + i]), 64'(16'(16'hFFFE + i)));
    check_job("wrap", 16'hFFFE, 16'h0E00, 16'd4, 16'd1, wb, db);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/dct_sequencer.md
# dct_sequencer

DMA-style sequencer for the DCT peripheral. The CPU programs a source buffer, a destination buffer, a length and a Q format, then issues GO. The block then runs the whole job without CPU involvement: it streams samples from data memory into the DCT's slave port, reads each result back (honouring the DCT's `done` stall), and writes the results to memory. It sits between the CPU config bus, the data-memory master port and the DCT slave.

## Interface
Parameters:
- `NBITS`, 16: sample/result width; equals the DCT `NBITS`.
- `ADDR_W`, 16: word-address width of the memory master.
- `MAX_SIZE`, 256: largest accepted LEN; equals the DCT `MAX_SIZE`.

Ports:
- `clk`, input, 1: clock.
- `Reset`, input, 1: asynchronous, active-high reset.
- `cfg_address`, input, 3: config register select.
- `cfg_write`, `cfg_read`, input, 1: single-cycle config access strobes.
- `cfg_writedata`, input, 16: config write data.
- `cfg_readdata`, output, 16: combinational read data; 0 when `cfg_read`=0.
- `mem_address`, output, ADDR_W: word address.
- `mem_read`, `mem_write`, output, 1: memory request strobes.
- `mem_writedata`, output, NBITS: memory write data.
- `mem_readdata`, input, NBITS: memory read data.
- `mem_waitrequest`, input, 1: stalls the current memory request.
- `dct_address`, output, 8: DCT register/result index.
- `dct_read`, `dct_write`, output, 1: DCT access strobes.
- `dct_writedata`, output, NBITS: DCT write data.
- `dct_readdata`, input, NBITS: DCT result data.
- `dct_done`, input, 1: DCT read-valid signal; 0 stalls the read.
- `irq`, output, 1: `done_flag & irq_en`.

## Operation
Config registers (indexed by `cfg_address`):
- 0 CTRL (write-only): bit0 = GO, bit1 = `irq_en`.
- 1 SRC, 2 DST, 3 LEN, 4 QM.
- 5 STATUS (read-only): bit0 busy, bit1 `done_flag`, bit2 `err`.
- All other addresses read 0.

Config write rules:
- Writes to SRC, DST, LEN and QM are ignored while busy.
- A GO while busy is ignored.
- A CTRL write while busy updates `irq_en` only.

GO handling:
- GO with LEN<2 or LEN>MAX_SIZE: sets `err`, clears `done_flag`, stays in IDLE.
- Valid GO: clears `err` and `done_flag`, enters SETQ.

FSM states:
- IDLE
- SETQ: one-cycle DCT write of QM to DCT address 3.
- START: one-cycle DCT write of LEN to DCT address 0. This also re-initialises the DCT.
- LOAD_RD: drives `mem_read` at SRC+i. Holds while `mem_waitrequest`=1. Captures `mem_readdata` in the cycle `mem_waitrequest`=0.
- LOAD_WR: one-cycle DCT write of the captured sample to DCT address 1. Then i++. If i was LEN-1, sets k=0 and goes to RES_RD; otherwise returns to LOAD_RD.
- RES_RD: drives `dct_read` with `dct_address`=k. Holds while `dct_done`=0. Captures `dct_readdata` in the cycle `dct_done`=1.
- RES_WR: drives `mem_write` of the captured result at DST+k. Holds while `mem_waitrequest`=1. On acceptance, k++. If k was LEN-1, goes to FIN; otherwise returns to RES_RD.
- FIN: sets `done_flag`, returns to IDLE.

Strobe and data-path rules:
- DCT writes never stall.
- At most one of `mem_read`, `mem_write`, `dct_read`, `dct_write` is high in any cycle.
- Data passes through unmodified; no arithmetic on samples.
- Memory addresses are SRC/DST plus offset, wrapping modulo 2^ADDR_W.
- Counters i and k are 9 bits wide.

## Timing
- Reset (asynchronous): state=IDLE. All strobes 0. All output address/data buses 0. `irq`=0. All registers, `done_flag` and `err` cleared.
- Reset mid-job: the job is abandoned. The DCT's own state is left as is; the next GO re-issues SETQ and START, which restarts it cleanly.
- GO written in cycle t: SETQ is in cycle t+1 and START in cycle t+2. The first `mem_read` is in cycle t+3.
- Each load, with zero memory wait, takes 2 cycles.
- Each result, with zero waits, takes 2 cycles.
- Total job latency is 2 + 2·LEN + Σ(DCT stall) + 2·LEN + 1 cycles, plus memory wait cycles.
- busy is 1 from cycle t+1 through FIN inclusive.
- `done_flag` rises in the cycle after FIN. `irq` follows `done_flag` combinationally.
- `done_flag` stays set until the next valid or invalid GO.

## Test plan
- LEN=4, QM=3, SRC memory = {0x1000, 0x1000, 0x1000, 0x1000}, golden DCT model -> DST[0]=0x2FFF, DST[1..3] match the model, STATUS=0x2. With `irq_en`=1, `irq`=1.
- LEN=1 GO, then LEN=257 GO -> STATUS=0x4 each time. No DCT or memory strobes.
- Random `mem_waitrequest` (50%) with LEN=16 -> results identical to the zero-wait run. Request address and data held stable throughout each stall.
- GO plus SRC/LEN writes issued while busy -> ignored. The job completes with the original parameters and exactly LEN DCT data writes.
- Reset asserted in LOAD_RD of job 1, then a new job with LEN=8 -> outputs 0 during reset. Job 2 results are correct, starting with SETQ and START.
- SRC=0xFFFE, LEN=4 -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
